// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_frame_ctrl_pkg: shared state encoding, error codes and default sync byte
package uart_rx_frame_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, HUNT, GET_LEN, GET_PAY, GET_CHK, DRAIN} state_t;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: valid/ready payload stream from the frame controller
interface uart_rx_frame_ctrl_if;
  logic [7:0] FrameData;
  logic FrameValid;
  logic FrameReady;
  logic FrameLast;
  modport master(output FrameData, FrameValid, FrameLast, input FrameReady);
  modport slave(input FrameData, FrameValid, FrameLast, output FrameReady);
endinterface

// File: rtl/uart_rx_frame_ctrl_frame_buf.sv
// frame_buf: simple dual-port payload RAM, synchronous write, registered read
module frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [AW-1:0] wa,
  input  logic [7:0] wd,
  input  logic [AW-1:0] ra,
  output logic [7:0] rd
);
  logic [7:0] mem [DEPTH];
  // write port
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // registered read port, cleared by reset so the output starts at zero
  always_ff @(posedge clk or posedge rst)
    if (rst) rd <= 8'd0;
    else rd <= mem[ra];
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: SYNC,LEN,payload,CHK frame parser; UART_RX_FRAME_TIMEOUT_EN adds an inter-byte timeout
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
  parameter int MAX_LEN = 16,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd320
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Enable,
  input  logic [7:0] CfgNBits,
  input  logic Tick,
  input  logic [7:0] RxData,
  input  logic RxDone,
  output logic RxEn,
  output logic [7:0] NBits,
  uart_rx_frame_ctrl_if.master frm,
  output logic FrameErr,
  output logic [1:0] ErrCode,
  output logic Overrun
);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  state_t state;
  logic rx_done_q, ch, hs, tmo;
  logic [4:0] len, idx, rd_ptr;
  logic [7:0] chk;
  logic [AW-1:0] rd_addr;
  assign ch = RxDone & ~rx_done_q;
  assign hs = frm.FrameValid & frm.FrameReady;
  assign RxEn = state != IDLE;
  assign rd_addr = AW'(state != DRAIN ? 5'd0 : hs && !frm.FrameLast ? rd_ptr + 5'd1 : rd_ptr);
  frame_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .clk(Clk), .rst(Rst), .we(state == GET_PAY && ch), .wa(AW'(idx)), .wd(RxData),
    .ra(rd_addr), .rd(frm.FrameData)
  );
`ifdef UART_RX_FRAME_TIMEOUT_EN
  logic tick_q, in_frame;
  logic [15:0] tcnt;
  assign in_frame = state == GET_LEN || state == GET_PAY || state == GET_CHK;
  assign tmo = in_frame && !ch && Tick && !tick_q && tcnt == TIMEOUT_TICKS - 16'd1;
  // counts Tick rising edges since the last character while a frame is being collected
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      tick_q <= 1'b0;
      tcnt <= 16'd0;
    end else begin
      tick_q <= Tick;
      tcnt <= !in_frame || ch || tmo ? 16'd0 : Tick && !tick_q ? tcnt + 16'd1 : tcnt;
    end
`else
  logic unused_tick;
  assign tmo = 1'b0;
  assign unused_tick = Tick ^ (^TIMEOUT_TICKS);
`endif
  // frame FSM with registered stream, error and overrun outputs
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state <= IDLE;
      rx_done_q <= 1'b0;
      NBits <= 8'd8;
      frm.FrameValid <= 1'b0;
      frm.FrameLast <= 1'b0;
      FrameErr <= 1'b0;
      ErrCode <= ERR_NONE;
      Overrun <= 1'b0;
      len <= 5'd0;
      idx <= 5'd0;
      rd_ptr <= 5'd0;
      chk <= 8'd0;
    end else begin
      rx_done_q <= RxDone;
      FrameErr <= 1'b0;
      Overrun <= 1'b0;
      if ((state == IDLE || state == HUNT) && CfgNBits >= 8'd6 && CfgNBits <= 8'd8) NBits <= CfgNBits;
      if (!Enable) begin
        state <= IDLE;
        frm.FrameValid <= 1'b0;
        frm.FrameLast <= 1'b0;
      end else if (tmo) begin
        state <= HUNT;
        FrameErr <= 1'b1;
        ErrCode <= ERR_TMO;
      end else case (state)
        IDLE: state <= HUNT;
        HUNT: if (ch && RxData == SYNC_BYTE) state <= GET_LEN;
        GET_LEN: if (ch) begin
          if (RxData == 8'd0 || RxData > 8'(MAX_LEN)) begin
            state <= HUNT;
            FrameErr <= 1'b1;
            ErrCode <= ERR_LEN;
          end else begin
            state <= GET_PAY;
            len <= RxData[4:0];
            idx <= 5'd0;
            chk <= RxData;
          end
        end
        GET_PAY: if (ch) begin
          chk <= chk ^ RxData;
          idx <= idx + 5'd1;
          if (idx == len - 5'd1) state <= GET_CHK;
        end
        GET_CHK: if (ch) begin
          if (RxData == chk) begin
            state <= DRAIN;
            rd_ptr <= 5'd0;
            frm.FrameValid <= 1'b1;
            frm.FrameLast <= len == 5'd1;
          end else begin
            state <= HUNT;
            FrameErr <= 1'b1;
            ErrCode <= ERR_CHK;
          end
        end
        DRAIN: begin
          Overrun <= ch;
          if (hs && frm.FrameLast) begin
            state <= HUNT;
            frm.FrameValid <= 1'b0;
            frm.FrameLast <= 1'b0;
          end else if (hs) begin
            rd_ptr <= rd_ptr + 5'd1;
            frm.FrameLast <= rd_ptr + 5'd2 == len;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
UART_RX_FRAME_CTRL -- requirements
Module: uart_rx_frame_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, 8'hA5, frame start marker.
REQ-002 Parameter MAX_LEN, 16, maximum payload bytes (1..31).
REQ-003 Parameter TIMEOUT_TICKS, 16'd320, inter-byte timeout in Tick rising edges.
REQ-004 The block SHALL use one clock and an asynchronous active-high reset; ports are Clk and Rst.
REQ-005 Clk  in  1  system clock.
REQ-006 Rst  in  1  asynchronous active-high reset.
REQ-007 Enable  in  1  controller enable; 0 forces IDLE.
REQ-008 CfgNBits  in  8  requested data bits per character.
REQ-009 Tick  in  1  16x baud tick shared with the receiver.
REQ-010 RxData  in  8  received character from the receiver.
REQ-011 RxDone  in  1  receiver character-complete strobe.
REQ-012 RxEn  out  1  receiver enable.
REQ-013 NBits  out  8  data-bit count applied to the receiver.
REQ-014 FrameData  out  8  payload byte.
REQ-015 FrameValid  out  1  FrameData valid.
REQ-016 FrameReady  in  1  consumer accepts FrameData.
REQ-017 FrameLast  out  1  final payload byte of the frame.
REQ-018 FrameErr  out  1  one-cycle error pulse.
REQ-019 ErrCode  out  2  last error: 01 bad length, 10 checksum, 11 timeout.
REQ-020 Overrun  out  1  one-cycle pulse when a character is dropped during DRAIN.

Function
REQ-021 A character SHALL be counted once, on the RxDone 0->1 edge sampled at posedge Clk; holding RxDone high SHALL NOT count again.
REQ-022 Frame format SHALL be SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK equals the XOR of LEN and all payload bytes.
REQ-023 States SHALL be IDLE, HUNT, GET_LEN, GET_PAY, GET_CHK and DRAIN.
REQ-024 IDLE SHALL go to HUNT when Enable=1; any state SHALL go to IDLE on the cycle after Enable=0, discarding buffered data.
REQ-025 HUNT SHALL discard characters other than SYNC_BYTE and go to GET_LEN on SYNC_BYTE.
REQ-026 In GET_LEN, LEN=0 or LEN>MAX_LEN SHALL raise error 01 and return to HUNT; otherwise the block SHALL go to GET_PAY.
REQ-027 GET_PAY SHALL write bytes into an internal MAX_LEN-entry buffer at an incrementing index; after LEN bytes it SHALL go to GET_CHK.
REQ-028 On a CHK match the block SHALL go to DRAIN; on a mismatch it SHALL raise error 10 and return to HUNT.
REQ-029 DRAIN SHALL present buffer entries 0..LEN-1 with FrameValid=1, advancing on FrameValid&FrameReady; FrameLast=1 SHALL accompany entry LEN-1.
REQ-030 FrameValid SHALL assert the cycle after CHK is accepted; FrameData SHALL be stable while FrameValid=1 and FrameReady=0.
REQ-031 After the last handshake the block SHALL go to HUNT on the next cycle.
REQ-032 Characters arriving in DRAIN SHALL be dropped with a pulse on Overrun.
REQ-033 RxEn SHALL equal 1 in every state except IDLE.
REQ-034 NBits SHALL load CfgNBits only in IDLE and HUNT, and only when CfgNBits is in 6..8; otherwise NBits SHALL hold its value.
REQ-035 FrameErr SHALL be a single-cycle pulse; ErrCode SHALL update in the same cycle and hold until the next error.

Reset
REQ-036 Reset SHALL give state IDLE, RxEn=0, NBits=8, FrameValid=0, FrameLast=0, FrameData=0, FrameErr=0, ErrCode=00, Overrun=0, and clear the counters and index.
REQ-037 Reset mid-frame or mid-drain SHALL abandon the frame, and no FrameValid SHALL occur until a new complete frame is received.

Configuration
REQ-038 With UART_RX_FRAME_TIMEOUT_EN defined, GET_LEN, GET_PAY and GET_CHK SHALL count Tick rising edges, clear the count on each character, and at TIMEOUT_TICKS raise error 11 and return to HUNT.
REQ-039 Without UART_RX_FRAME_TIMEOUT_EN, no timeout counter SHALL exist and ErrCode 11 SHALL never occur.

Structure
REQ-040 A shared package SHALL hold the state enumeration, the ErrCode constants and the default SYNC_BYTE.
REQ-041 The payload buffer SHALL be a sub-module, frame_buf, implemented as a simple dual-port RAM with a synchronous write port and a registered read port.

Verification
REQ-042 A5,03,11,22,33,CHK=03 with FrameReady=1 -> FrameData 11,22,33 on consecutive cycles, FrameLast on 33, no FrameErr.
REQ-043 A5,02,10,20,CHK=00 -> FrameErr with ErrCode=10, no FrameValid, back to HUNT.
REQ-044 A5,00 and A5,11 with MAX_LEN=16 -> two FrameErr pulses with ErrCode=01.
REQ-045 With TIMEOUT_EN: A5,04,01 then 320 Ticks of silence -> ErrCode=11; a following valid frame is delivered correctly.
REQ-046 A valid 2-byte frame with FrameReady=0, then a character arriving, then FrameReady=1 -> Overrun pulse; FrameData held stable, then both bytes delivered.
